// File: rtl/pipe_stage_fifo.sv
// Elastic valid/ready pipeline register between two core stages.
// DEPTH-entry first-word-fall-through buffer with flush, registered in_ready and perf counters.
module pipe_stage_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           stall_cycles,
    output logic [CNT_W-1:0]           flushed_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
    localparam logic [SUM_W-1:0] SAT_MAX  = SUM_W'({CNT_W{1'b1}});

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("pipe_stage_fifo: DEPTH must be >= 2");
        end
        if (DATA_W < 1) begin : g_bad_width
            $error("pipe_stage_fifo: DATA_W must be >= 1");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flushed_q, flushed_d;
    logic [SUM_W-1:0]  flush_sum;
    logic              push, pop;

    // Upstream ready depends on the occupancy flop alone, so it never sees out_ready or flush.
    assign in_ready     = (count_q != FULL_CNT);
    assign out_valid    = (count_q != '0);
    assign out_data     = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign stall_cycles = stall_q;
    assign flushed_cnt  = flushed_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        stall_d   = stall_q;
        flushed_d = flushed_q;
        flush_sum = '0;

        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (flush) begin
            // A head popped in the flush cycle reaches downstream, so it is not counted as lost.
            flush_sum = SUM_W'(flushed_q) + SUM_W'(count_q - OCC_W'(pop));
            flushed_d = (flush_sum > SAT_MAX) ? '1 : CNT_W'(flush_sum);
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            stall_q   <= stall_d;
            flushed_q <= flushed_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; out_valid qualifies whatever it holds.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Self-checking bench for pipe_stage_fifo: instance A (DEPTH=2, CNT_W=4) and B (DEPTH=3).
// Drivers push expected beats into scoreboards; negedge monitors pop and compare on handshakes.
module tb_pipe_stage_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_count;
    logic [3:0] a_stall, a_flushed;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [1:0]  b_count;
    logic [31:0] b_stall, b_flushed;

    pipe_stage_fifo #(.DATA_W(8), .DEPTH(2), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count), .stall_cycles(a_stall), .flushed_cnt(a_flushed)
    );

    pipe_stage_fifo #(.DATA_W(8), .DEPTH(3), .CNT_W(32)) dut_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count), .stall_cycles(b_stall), .flushed_cnt(b_flushed)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    // Reference model of instance A (DEPTH=2, 4-bit saturating counters).
    int mcnt, mstall, mflushed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat4(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    always @(negedge clk) begin
        if (mon_en && a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_out: got 0x%0h expected no output at %0t", a_out_data, $time);
            end else begin
                check("a_out_data", a_out_data, qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_out: got 0x%0h expected no output at %0t", b_out_data, $time);
            end else begin
                check("b_out_data", b_out_data, qb.pop_front());
            end
        end
    end

    // One cycle on instance A: drive, check registered state at negedge, then advance the model.
    task automatic step_a(input logic v, input logic [7:0] d, input logic r,
                          input logic fl, input logic rst, input bit chk);
        bit push, pop;
        a_in_valid  = v;
        a_in_data   = d;
        a_out_ready = r;
        a_flush     = fl;
        reset       = rst;
        @(negedge clk);
        if (chk) begin
            check("a_in_ready", a_in_ready, (mcnt != 2) ? 1 : 0);
            check("a_out_valid", a_out_valid, (mcnt != 0) ? 1 : 0);
            check("a_count", a_count, mcnt);
            check("a_stall", a_stall, mstall);
            check("a_flushed", a_flushed, mflushed);
        end
        @(posedge clk);
        push = v && (mcnt != 2);
        pop  = r && (mcnt != 0);
        if (rst) begin
            mcnt = 0; mstall = 0; mflushed = 0;
            qa.delete();
        end else begin
            if (mcnt != 0 && !r) mstall = sat4(mstall + 1);
            if (fl) begin
                mflushed = sat4(mflushed + mcnt - (pop ? 1 : 0));
                mcnt = 0;
                qa.delete();
            end else begin
                mcnt = mcnt + (push ? 1 : 0) - (pop ? 1 : 0);
                if (push) qa.push_back(d);
            end
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        mcnt = 0; mstall = 0; mflushed = 0;
        @(posedge clk);
        #1;
        step_a(0, 8'h00, 0, 0, 1, 0);
        step_a(0, 8'h00, 0, 0, 1, 0);
        mon_en = 1'b1;

        // Reset state, then T1: single beat with one-cycle latency.
        step_a(0, 8'h00, 0, 0, 0, 1);
        step_a(1, 8'hA1, 0, 0, 0, 1);
        step_a(0, 8'h00, 0, 0, 0, 1);
        step_a(0, 8'h00, 1, 0, 0, 1);
        step_a(0, 8'h00, 0, 0, 0, 1);

        // T2: fill to DEPTH with downstream stalled, third beat held off, then drain in order.
        step_a(1, 8'h11, 0, 0, 0, 1);
        step_a(1, 8'h22, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step_a(1, 8'h33, 0, 0, 0, 1);
        step_a(1, 8'h33, 1, 0, 0, 1);
        step_a(1, 8'h33, 1, 0, 0, 1);
        step_a(0, 8'h00, 1, 0, 0, 1);
        step_a(0, 8'h00, 0, 0, 0, 1);

        // T3: instance B streams 20 beats at one per cycle across repeated pointer wraps.
        for (int i = 0; i < 20; i++) begin
            b_in_valid  = 1'b1;
            b_in_data   = 8'(i);
            b_out_ready = 1'b1;
            @(negedge clk);
            check("b_count", b_count, (i == 0) ? 0 : 1);
            check("b_in_ready", b_in_ready, 1);
            @(posedge clk);
            qb.push_back(8'(i));
            #1;
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        check("b_count_tail", b_count, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b_count_empty", b_count, 0);
        check("b_scoreboard_empty", qb.size(), 0);
        b_out_ready = 1'b0;
        @(posedge clk);
        #1;

        // T4: flush while full with a push offered, then flush with a push actually accepted.
        step_a(1, 8'h44, 0, 0, 0, 1);
        step_a(1, 8'h45, 0, 0, 0, 1);
        step_a(1, 8'h55, 0, 1, 0, 1);
        step_a(1, 8'h56, 0, 0, 0, 1);
        step_a(1, 8'h57, 0, 1, 0, 1);
        step_a(0, 8'h00, 1, 0, 0, 1);
        step_a(0, 8'h00, 1, 0, 0, 1);

        // T5: full with pop and offered push in the same cycle; then flush coinciding with a pop.
        step_a(1, 8'h61, 0, 0, 0, 1);
        step_a(1, 8'h62, 0, 0, 0, 1);
        step_a(1, 8'h63, 1, 0, 0, 1);
        step_a(0, 8'h00, 0, 0, 0, 1);
        step_a(0, 8'h00, 1, 0, 0, 1);
        step_a(1, 8'h71, 0, 0, 0, 1);
        step_a(1, 8'h72, 0, 0, 0, 1);
        step_a(0, 8'h00, 1, 1, 0, 1);
        step_a(0, 8'h00, 1, 0, 0, 1);

        // T6: stall counter saturates at 15, then reset mid-stream dominates push and flush.
        step_a(0, 8'h00, 0, 0, 1, 1);
        step_a(1, 8'h81, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step_a(0, 8'h00, 0, 0, 0, 1);
        @(negedge clk);
        check("a_stall_saturated", a_stall, 4'hF);
        @(posedge clk);
        #1;
        step_a(1, 8'h82, 0, 1, 1, 1);
        step_a(0, 8'h00, 1, 0, 0, 1);
        step_a(0, 8'h00, 1, 0, 0, 1);
        check("a_scoreboard_empty", qa.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
